wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Write-back (W) stage of the five-stage MIPS pipeline. It sits between the M stage and the register file.
- Registers M-stage results on the clock edge. Selects and extends the write-back value: ALU result, extended load data, or PC+8.
- Drives the register file's write address, write data and write PC directly.
- The register file has no write enable and writes whenever its address is nonzero. This stage therefore encodes bubbles as write address 0. It also keeps a retired-instruction counter.

Parameters:
- RESET_PC, 32'h0000_3000, value of WritePC after reset and during bubbles.

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- en  in  1  capture enable; 0 holds the current W contents
- clr  in  1  synchronous bubble insert; overrides en
- m_valid  in  1  M-stage slot holds a real instruction
- m_pc  in  32  PC of M-stage instruction
- m_waddr  in  5  destination register (0 = no write)
- m_wsel  in  2  source select: 0 ALU, 1 MEM, 2 PC+8, 3 reserved (treated as ALU)
- m_alu_result  in  32  ALU result; bits [1:0] also serve as load byte offset
- m_mem_rdata  in  32  aligned word read from data memory
- m_load_type  in  3  0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5-7 treated as LW
- WAddr  out  5  register file write address (0 = no write)
- WriteData  out  32  register file write data
- WritePC  out  32  PC of the instruction being written, used for the trace
- w_valid  out  1  W stage holds a real instruction
- retire_count  out  32  instructions captured into W since reset

Behaviour:
- Reset (async, active-high): WAddr=0, WriteData=0, WritePC=RESET_PC, w_valid=0, retire_count=0. Outputs take these values immediately when reset is asserted, not at the next edge.
- Clock-edge priority at each rising clk edge with reset low:
  - clr=1: capture a bubble, whatever en is.
  - else en=0: hold all registers.
  - else en=1: capture from the M stage.
- Bubble: WAddr=0, WriteData=0, WritePC=RESET_PC, w_valid=0.
- Capture with m_valid=0: same as bubble.
- Capture with m_valid=1:
  - w_valid=1, WritePC=m_pc, WAddr=m_waddr.
  - WriteData is the selected value. It is forced to 0 when m_waddr=0, so a write to $0 is a full no-op on the port.
- Latency: M-stage inputs appear on the outputs one cycle after the capturing edge. Outputs are purely registered, with no combinational path from inputs.
- Write-data selection, computed before the register:
  - wsel=0 or 3: m_alu_result.
  - wsel=1: extended load value (see below).
  - wsel=2: m_pc + 32'd8, modulo 2^32 (m_pc=FFFF_FFFC gives 0000_0004).
- Load extension uses offset o = m_alu_result[1:0]:
  - LW: full word.
  - LB: byte o sign-extended. LBU: byte o zero-extended.
  - LH/LHU: halfword m_alu_result[1] (0 = bits 15:0, 1 = bits 31:16); sign- or zero-extended; m_alu_result[0] is ignored.
  - Byte o means bits [8o+7:8o].
- retire_count:
  - Increments by 1 on every edge that captures with clr=0, en=1 and m_valid=1. This includes instructions with m_waddr=0, such as sw and branches.
  - Wraps from FFFF_FFFF to 0.
  - Holds on hold edges and bubble edges.
- Reset mid-operation: all state is discarded immediately. The first capture after reset release is on the first rising edge with reset low.
- No internal write-to-read bypass; the register file handles same-cycle read-after-write.

Test Plan:
- Assert reset mid-run with WAddr=5 live -> WAddr=0, WriteData=0, WritePC=3000, retire_count=0 before the next edge.
- Load extension, with m_mem_rdata=8765_43F1, wsel=1, m_valid=1, en=1 and m_waddr=8:
  - LB at offset 0 -> WriteData FFFF_FFF1; LBU at offset 0 -> 0000_00F1.
  - LH at offset 2 -> FFFF_8765; LHU at offset 3 -> 0000_8765; LW -> 8765_43F1.
- wsel=2, m_pc=0000_3010, m_waddr=31 -> next cycle WAddr=31, WriteData=0000_3018, WritePC=0000_3010.
- Hold and clear:
  - en=0 for 3 cycles with new M values applied -> outputs unchanged.
  - Then clr=1 with en=0 -> bubble: WAddr=0, w_valid=0; retire_count unchanged.
- m_waddr=0, wsel=0, m_alu_result=DEAD_BEEF, m_valid=1 -> WAddr=0, WriteData=0, w_valid=1, retire_count increments.
- Counter wrap: preload by running 2^32-1 captures, or use a bench force of FFFF_FFFF, then one valid capture -> retire_count=0.

Source files
------------

// File: rtl/wb_stage_if.sv
// wb_stage_if
//   Bundles the M-to-W pipeline slot and the register-file write port
//   of the write-back stage.
//   slave  : used by wb_stage. It receives the M-stage slot and the
//            en/clr controls, and drives the W outputs.
//   master : used by whatever drives the M stage, such as the bench.
//   Signals:
//     en, clr      capture enable / synchronous bubble insert
//     m_*          M-stage instruction slot
//     WAddr        register file write address (0 = no write)
//     WriteData    register file write data
//     WritePC      PC of the instruction being written
//     w_valid      W holds a real instruction
//     retire_count instructions captured since reset
interface wb_stage_if;
  logic        en;
  logic        clr;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [4:0]  m_waddr;
  logic [1:0]  m_wsel;
  logic [31:0] m_alu_result;
  logic [31:0] m_mem_rdata;
  logic [2:0]  m_load_type;
  logic [4:0]  WAddr;
  logic [31:0] WriteData;
  logic [31:0] WritePC;
  logic        w_valid;
  logic [31:0] retire_count;

  modport slave (
    input  en, clr, m_valid, m_pc, m_waddr, m_wsel,
           m_alu_result, m_mem_rdata, m_load_type,
    output WAddr, WriteData, WritePC, w_valid, retire_count
  );

  modport master (
    output en, clr, m_valid, m_pc, m_waddr, m_wsel,
           m_alu_result, m_mem_rdata, m_load_type,
    input  WAddr, WriteData, WritePC, w_valid, retire_count
  );
endinterface

// File: rtl/wb_stage.sv
// wb_stage
//   Write-back stage of the five-stage MIPS pipeline. It registers the
//   M-stage result and selects the write-back value: ALU result,
//   extended load data, or PC+8. It drives the register file write port
//   and counts retired instructions.
//   Bubbles are encoded as write address 0, because the register file
//   has no write enable.
//   Ports:
//     clk    pipeline clock, rising edge
//     reset  asynchronous, active-high; clears all state immediately
//     bus    wb_stage_if.slave (M-stage slot in, write port out)
module wb_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  wb_stage_if.slave   bus
);

  logic [4:0]  r_waddr;
  logic [31:0] r_wdata;
  logic [31:0] r_wpc;
  logic        r_valid;
  logic [31:0] r_retire_count;

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_sel_data;
  logic [31:0] w_wdata;

  always_comb begin
    w_byte = bus.m_mem_rdata[7:0];
    case (bus.m_alu_result[1:0])
      2'd0:    w_byte = bus.m_mem_rdata[7:0];
      2'd1:    w_byte = bus.m_mem_rdata[15:8];
      2'd2:    w_byte = bus.m_mem_rdata[23:16];
      default: w_byte = bus.m_mem_rdata[31:24];
    endcase

    // Halfword loads ignore address bit 0.
    w_half = bus.m_alu_result[1] ? bus.m_mem_rdata[31:16] : bus.m_mem_rdata[15:0];

    // Undefined load types 5-7 fall back to a full-word load.
    case (bus.m_load_type)
      3'd1:    w_load_data = {{24{w_byte[7]}}, w_byte};
      3'd2:    w_load_data = {24'd0, w_byte};
      3'd3:    w_load_data = {{16{w_half[15]}}, w_half};
      3'd4:    w_load_data = {16'd0, w_half};
      default: w_load_data = bus.m_mem_rdata;
    endcase

    // Select code 3 is reserved and behaves as an ALU select.
    case (bus.m_wsel)
      2'd1:    w_sel_data = w_load_data;
      2'd2:    w_sel_data = bus.m_pc + 32'd8;
      default: w_sel_data = bus.m_alu_result;
    endcase

    // A write to $0 is a full no-op on the port, data included.
    w_wdata = (bus.m_waddr == 5'd0) ? 32'd0 : w_sel_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_waddr        <= 5'd0;
      r_wdata        <= 32'd0;
      r_wpc          <= RESET_PC;
      r_valid        <= 1'b0;
      r_retire_count <= 32'd0;
    end else if (bus.clr || (bus.en && !bus.m_valid)) begin
      r_waddr <= 5'd0;
      r_wdata <= 32'd0;
      r_wpc   <= RESET_PC;
      r_valid <= 1'b0;
    end else if (bus.en) begin
      r_waddr        <= bus.m_waddr;
      r_wdata        <= w_wdata;
      r_wpc          <= bus.m_pc;
      r_valid        <= 1'b1;
      // The counter includes instructions with no register write, such as stores and branches.
      r_retire_count <= r_retire_count + 32'd1;
    end
  end

  assign bus.WAddr        = r_waddr;
  assign bus.WriteData    = r_wdata;
  assign bus.WritePC      = r_wpc;
  assign bus.w_valid      = r_valid;
  assign bus.retire_count = r_retire_count;

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage
//   Directed-vector bench for wb_stage with hand-computed expectations.
module tb_wb_stage;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  wb_stage_if bus ();

  wb_stage #(.RESET_PC(32'h0000_3000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Apply an M-stage slot with en=1, clr=0, then capture it on the next edge.
  task automatic cap(input logic v, input logic [31:0] pc, input logic [4:0] wa,
                     input logic [1:0] ws, input logic [31:0] alu,
                     input logic [31:0] rd, input logic [2:0] lt);
    bus.en = 1'b1; bus.clr = 1'b0;
    bus.m_valid = v; bus.m_pc = pc; bus.m_waddr = wa; bus.m_wsel = ws;
    bus.m_alu_result = alu; bus.m_mem_rdata = rd; bus.m_load_type = lt;
    @(posedge clk); #1;
  endtask

  task automatic check_w(input string tag, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] pc, input logic v, input logic [31:0] rc);
    check_val({tag, ".waddr"}, {27'd0, bus.WAddr}, {27'd0, wa});
    check_val({tag, ".wdata"}, bus.WriteData, wd);
    check_val({tag, ".wpc"}, bus.WritePC, pc);
    check_val({tag, ".valid"}, {31'd0, bus.w_valid}, {31'd0, v});
    check_val({tag, ".retire"}, bus.retire_count, rc);
  endtask

  localparam logic [31:0] RD = 32'h8765_43F1;

  initial begin
    n_checks = 0; n_errors = 0;
    reset = 1'b1;
    bus.en = 1'b0; bus.clr = 1'b0; bus.m_valid = 1'b0; bus.m_pc = 32'd0;
    bus.m_waddr = 5'd0; bus.m_wsel = 2'd0; bus.m_alu_result = 32'd0;
    bus.m_mem_rdata = 32'd0; bus.m_load_type = 3'd0;
    #1;
    check_w("reset", 5'd0, 32'd0, 32'h3000, 1'b0, 32'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    @(posedge clk); #1;
    check_w("idle_after_reset", 5'd0, 32'd0, 32'h3000, 1'b0, 32'd0);

    // Load extension
    cap(1, 32'h3000, 8, 1, 32'h0, RD, 1);  check_w("lb_o0",  8, 32'hFFFF_FFF1, 32'h3000, 1, 1);
    cap(1, 32'h3004, 8, 1, 32'h0, RD, 2);  check_w("lbu_o0", 8, 32'h0000_00F1, 32'h3004, 1, 2);
    cap(1, 32'h3008, 8, 1, 32'h2, RD, 3);  check_w("lh_o2",  8, 32'hFFFF_8765, 32'h3008, 1, 3);
    cap(1, 32'h300C, 8, 1, 32'h3, RD, 4);  check_w("lhu_o3", 8, 32'h0000_8765, 32'h300C, 1, 4);
    cap(1, 32'h3010, 8, 1, 32'h0, RD, 0);  check_w("lw",     8, 32'h8765_43F1, 32'h3010, 1, 5);
    cap(1, 32'h3014, 9, 1, 32'h1, RD, 1);  check_w("lb_o1",  9, 32'h0000_0043, 32'h3014, 1, 6);
    cap(1, 32'h3018, 9, 1, 32'h3, RD, 1);  check_w("lb_o3",  9, 32'hFFFF_FF87, 32'h3018, 1, 7);
    cap(1, 32'h301C, 9, 1, 32'h1, RD, 3);  check_w("lh_o1",  9, 32'h0000_43F1, 32'h301C, 1, 8);
    cap(1, 32'h3020, 9, 1, 32'h2, RD, 6);  check_w("lt6_lw", 9, 32'h8765_43F1, 32'h3020, 1, 9);
    cap(1, 32'h3024, 9, 1, 32'h2, RD, 2);  check_w("lbu_o2", 9, 32'h0000_0065, 32'h3024, 1, 10);

    // PC+8 and reserved select
    cap(1, 32'h3010, 31, 2, 32'h0, RD, 0); check_w("pc8", 31, 32'h0000_3018, 32'h3010, 1, 11);
    cap(1, 32'hFFFF_FFFC, 4, 2, 32'h0, RD, 0); check_w("pc8_wrap", 4, 32'h0000_0004, 32'hFFFF_FFFC, 1, 12);
    cap(1, 32'h3030, 3, 3, 32'h1234_5678, RD, 1); check_w("wsel3", 3, 32'h1234_5678, 32'h3030, 1, 13);

    // Hold for three cycles while M-stage inputs change
    cap(1, 32'h3100, 5, 0, 32'h0000_A5A5, RD, 0); check_w("pre_hold", 5, 32'h0000_A5A5, 32'h3100, 1, 14);
    for (int i = 0; i < 3; i++) begin
      bus.en = 1'b0;
      bus.m_pc = 32'h4000 + i; bus.m_waddr = 5'd20 + 5'(i); bus.m_alu_result = 32'h1111_0000 + i;
      @(posedge clk); #1;
      check_w("hold", 5, 32'h0000_A5A5, 32'h3100, 1, 14);
    end
    bus.clr = 1'b1; bus.en = 1'b0;
    @(posedge clk); #1;
    check_w("clr_en0", 0, 32'd0, 32'h3000, 0, 14);

    // clr overrides en with a valid slot present
    cap(1, 32'h3200, 7, 0, 32'h77, RD, 0); check_w("valid7", 7, 32'h77, 32'h3200, 1, 15);
    bus.clr = 1'b1; bus.en = 1'b1; bus.m_valid = 1'b1;
    @(posedge clk); #1;
    check_w("clr_en1", 0, 32'd0, 32'h3000, 0, 15);

    // Capture with m_valid=0 acts as a bubble and does not count
    cap(1, 32'h3204, 7, 0, 32'h88, RD, 0); check_w("valid7b", 7, 32'h88, 32'h3204, 1, 16);
    cap(0, 32'h3208, 7, 0, 32'h99, RD, 0); check_w("mvalid0", 0, 32'd0, 32'h3000, 0, 16);

    // Write to $0: no-op on the port but still retires
    cap(1, 32'h3300, 0, 0, 32'hDEAD_BEEF, RD, 0); check_w("waddr0", 0, 32'd0, 32'h3300, 1, 17);

    // Asynchronous reset mid-run
    cap(1, 32'h3400, 5, 0, 32'h5555, RD, 0); check_w("pre_rst", 5, 32'h5555, 32'h3400, 1, 18);
    #2 reset = 1'b1;
    #1 check_w("async_rst", 0, 32'd0, 32'h3000, 0, 0);
    @(posedge clk); #3;
    reset = 1'b0;
    cap(1, 32'h3500, 6, 0, 32'h66, RD, 0); check_w("post_rst", 6, 32'h66, 32'h3500, 1, 1);

    // Counter wrap via a preloaded count
    force dut.r_retire_count = 32'hFFFF_FFFF;
    #1 release dut.r_retire_count;
    #1 check_val("preload", bus.retire_count, 32'hFFFF_FFFF);
    cap(1, 32'h3600, 2, 0, 32'h22, RD, 0); check_w("wrap", 2, 32'h22, 32'h3600, 1, 0);
    cap(1, 32'h3604, 2, 0, 32'h23, RD, 0); check_val("after_wrap", bus.retire_count, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
